// File: rtl/ddr_hit_judge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_judge_pkg
//  Purpose  : Shared types and helpers for the dance-game hit judge:
//             per-lane judge result encoding, point values and a
//             saturating adder used by the per-player combo counters.
//  Revision : 1.0  initial release
// ============================================================================
package ddr_judge_pkg;

  // Result produced by one player-lane window in a single cycle.
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    PERFECT = 3'd1,
    GOOD    = 3'd2,
    MISS    = 3'd3,
    STRAY   = 3'd4
  } judge_e;

  // Points awarded per graded hit.
  localparam int unsigned PTS_PERFECT = 3;
  localparam int unsigned PTS_GOOD    = 1;

  // Unsigned add clamped to max_val; one extra bit keeps the carry visible.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      sat_add = max_val;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_hit_judge_if.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_hit_judge_if
//  Purpose  : Bundle of game-control, note, key and score signals between
//             the game front end (master) and the hit judge (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface ddr_hit_judge_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_LANES   = 4,
  parameter int SCORE_W     = 7,
  parameter int COMBO_W     = 8
);

  logic                             tick;
  logic                             game_active;
  logic                             clear_scores;
  logic                             note_valid;
  logic [NUM_LANES-1:0]             note_lanes;
  logic [NUM_PLAYERS*NUM_LANES-1:0] player_keys;
  logic [NUM_PLAYERS*SCORE_W-1:0]   score;
  logic [NUM_PLAYERS*COMBO_W-1:0]   combo;
  logic [NUM_PLAYERS-1:0]           perfect_hit;
  logic [NUM_PLAYERS-1:0]           good_hit;
  logic [NUM_PLAYERS-1:0]           miss;

  // Game front end: drives timing, notes and keys, observes results.
  modport master (
    output tick, game_active, clear_scores, note_valid, note_lanes, player_keys,
    input  score, combo, perfect_hit, good_hit, miss
  );

  // Hit judge: consumes timing, notes and keys, produces results.
  modport slave (
    input  tick, game_active, clear_scores, note_valid, note_lanes, player_keys,
    output score, combo, perfect_hit, good_hit, miss
  );

endinterface
`default_nettype wire

// File: rtl/ddr_hit_judge_lane_judge.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_lane_judge
//  Purpose  : Timing window for one player-lane. A note arms the window at
//             age 0; age advances on tick; a key press grades the note by
//             age, and running off the end of the window reports a miss.
//             The result is combinational and registered by the parent.
//  Revision : 1.0  initial release
// ============================================================================
module ddr_lane_judge
  import ddr_judge_pkg::*;
#(
  parameter int WIN_PERFECT = 2,
  parameter int WIN_GOOD    = 6
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_active,
  input  logic   i_clear,
  input  logic   i_note,
  input  logic   i_press,
  input  logic   i_tick,
  output judge_e o_result
);

  localparam int c_AGE_W = (WIN_GOOD > 1) ? $clog2(WIN_GOOD) : 1;
  localparam logic [c_AGE_W-1:0] c_AGE_PERFECT = c_AGE_W'(WIN_PERFECT);
  localparam logic [c_AGE_W-1:0] c_AGE_LAST    = c_AGE_W'(WIN_GOOD - 1);

  typedef enum logic [0:0] {
    LANE_IDLE  = 1'b0,
    LANE_ARMED = 1'b1
  } lane_state_e;

  lane_state_e        r_state;
  lane_state_e        w_state_nxt;
  logic [c_AGE_W-1:0] r_age;
  logic [c_AGE_W-1:0] w_age_nxt;
  judge_e             w_result;

  // Window state and age register; reset discards any open window silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LANE_IDLE;
      r_age   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_age   <= w_age_nxt;
    end
  end

  // Next-state and judge decision; a press always outranks expiry or re-arm.
  always_comb begin
    w_state_nxt = r_state;
    w_age_nxt   = r_age;
    w_result    = NONE;
    if (!i_active || i_clear) begin
      w_state_nxt = LANE_IDLE;
      w_age_nxt   = '0;
    end else begin
      case (r_state)
        LANE_IDLE: begin
          if (i_note && i_press) begin
            // Note and press coincide: graded at age 0, nothing left armed.
            w_result = PERFECT;
          end else if (i_note) begin
            w_state_nxt = LANE_ARMED;
            w_age_nxt   = '0;
          end else if (i_press) begin
            w_result = STRAY;
          end
        end
        LANE_ARMED: begin
          if (i_press) begin
            // Age never reaches WIN_GOOD while armed, so this is the full grade.
            w_result    = (r_age < c_AGE_PERFECT) ? PERFECT : GOOD;
            w_state_nxt = i_note ? LANE_ARMED : LANE_IDLE;
            w_age_nxt   = '0;
          end else if (i_note) begin
            // Unanswered note is replaced: old one misses, new one starts fresh.
            w_result  = MISS;
            w_age_nxt = '0;
          end else if (i_tick) begin
            if (r_age == c_AGE_LAST) begin
              w_result    = MISS;
              w_state_nxt = LANE_IDLE;
              w_age_nxt   = '0;
            end else begin
              w_age_nxt = r_age + c_AGE_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = LANE_IDLE;
          w_age_nxt   = '0;
        end
      endcase
    end
  end

  assign o_result = w_result;

endmodule
`default_nettype wire

// File: rtl/ddr_hit_judge.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_hit_judge
//  Purpose  : N-player x L-lane hit judge. Detects key presses, runs one
//             timing window per player-lane, tallies the per-player results
//             each cycle and keeps saturating score and combo counters plus
//             one-cycle perfect/good/miss pulses, all registered.
//  Revision : 1.0  initial release
// ============================================================================
module ddr_hit_judge
  import ddr_judge_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_LANES   = 4,
  parameter int WIN_PERFECT = 2,
  parameter int WIN_GOOD    = 6,
  parameter int SCORE_W     = 7,
  parameter int SCORE_MAX   = 99,
  parameter int COMBO_W     = 8
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  ddr_hit_judge_if.slave bus
);

  localparam int c_LANES_TOT = NUM_PLAYERS * NUM_LANES;
  localparam int c_CNT_W     = $clog2(NUM_LANES + 1);
  localparam int c_SUM_W     = SCORE_W + 3;
  localparam logic [31:0] c_COMBO_MAX = 32'((64'd1 << COMBO_W) - 64'd1);

  logic [c_LANES_TOT-1:0]         r_keys_prev;
  logic [c_LANES_TOT-1:0]         w_press;
  judge_e                         w_result [c_LANES_TOT];

  logic [c_CNT_W-1:0]             w_cnt_perf  [NUM_PLAYERS];
  logic [c_CNT_W-1:0]             w_cnt_good  [NUM_PLAYERS];
  logic [c_CNT_W-1:0]             w_cnt_miss  [NUM_PLAYERS];
  logic [c_CNT_W-1:0]             w_cnt_stray [NUM_PLAYERS];
  logic [c_SUM_W-1:0]             w_score_sum [NUM_PLAYERS];

  logic [NUM_PLAYERS*SCORE_W-1:0] r_score;
  logic [NUM_PLAYERS*SCORE_W-1:0] w_score_nxt;
  logic [NUM_PLAYERS*COMBO_W-1:0] r_combo;
  logic [NUM_PLAYERS*COMBO_W-1:0] w_combo_nxt;
  logic [NUM_PLAYERS-1:0]         r_perfect;
  logic [NUM_PLAYERS-1:0]         r_good;
  logic [NUM_PLAYERS-1:0]         r_miss;
  logic [NUM_PLAYERS-1:0]         w_perf_nxt;
  logic [NUM_PLAYERS-1:0]         w_good_nxt;
  logic [NUM_PLAYERS-1:0]         w_miss_nxt;

  // Previous key levels; reset to all ones so a key held through reset
  // is not taken as a press. Tracks keys even while the game is inactive.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_keys_prev <= '1;
    end else begin
      r_keys_prev <= bus.player_keys;
    end
  end

  assign w_press = bus.player_keys & ~r_keys_prev;

  // One timing window per player-lane; notes are shared by all players.
  generate
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ddr_lane_judge #(
          .WIN_PERFECT (WIN_PERFECT),
          .WIN_GOOD    (WIN_GOOD)
        ) u_lane (
          .clk      (CLOCK_50),
          .rst_n    (reset),
          .i_active (bus.game_active),
          .i_clear  (bus.clear_scores),
          .i_note   (bus.note_valid & bus.note_lanes[l]),
          .i_press  (w_press[p*NUM_LANES + l]),
          .i_tick   (bus.tick),
          .o_result (w_result[p*NUM_LANES + l])
        );
      end
    end
  endgenerate

  // Per-player tally of lane results and next score/combo/pulse values.
  always_comb begin
    w_score_nxt = r_score;
    w_combo_nxt = r_combo;
    w_perf_nxt  = '0;
    w_good_nxt  = '0;
    w_miss_nxt  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_cnt_perf[p]  = '0;
      w_cnt_good[p]  = '0;
      w_cnt_miss[p]  = '0;
      w_cnt_stray[p] = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        case (w_result[p*NUM_LANES + l])
          PERFECT: w_cnt_perf[p]  = w_cnt_perf[p]  + c_CNT_W'(1);
          GOOD:    w_cnt_good[p]  = w_cnt_good[p]  + c_CNT_W'(1);
          MISS:    w_cnt_miss[p]  = w_cnt_miss[p]  + c_CNT_W'(1);
          STRAY:   w_cnt_stray[p] = w_cnt_stray[p] + c_CNT_W'(1);
          default: ;
        endcase
      end

      // Widened sum so a near-full score cannot wrap before the clamp.
      w_score_sum[p] = c_SUM_W'(r_score[p*SCORE_W +: SCORE_W])
                     + c_SUM_W'(PTS_PERFECT) * c_SUM_W'(w_cnt_perf[p])
                     + c_SUM_W'(PTS_GOOD)    * c_SUM_W'(w_cnt_good[p]);
      if (w_score_sum[p] > c_SUM_W'(SCORE_MAX)) begin
        w_score_nxt[p*SCORE_W +: SCORE_W] = SCORE_W'(SCORE_MAX);
      end else begin
        w_score_nxt[p*SCORE_W +: SCORE_W] = w_score_sum[p][SCORE_W-1:0];
      end

      // Any miss or stray press ends the streak, even alongside hits.
      if ((w_cnt_miss[p] != '0) || (w_cnt_stray[p] != '0)) begin
        w_combo_nxt[p*COMBO_W +: COMBO_W] = '0;
      end else begin
        w_combo_nxt[p*COMBO_W +: COMBO_W] = COMBO_W'(sat_add(
            32'(r_combo[p*COMBO_W +: COMBO_W]),
            32'(w_cnt_perf[p]) + 32'(w_cnt_good[p]),
            c_COMBO_MAX));
      end

      w_perf_nxt[p] = (w_cnt_perf[p] != '0);
      w_good_nxt[p] = (w_cnt_good[p] != '0);
      w_miss_nxt[p] = (w_cnt_miss[p] != '0);
    end
  end

  // Registered score, combo and judge pulses; clear wins over any event.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_score   <= '0;
      r_combo   <= '0;
      r_perfect <= '0;
      r_good    <= '0;
      r_miss    <= '0;
    end else if (bus.clear_scores) begin
      r_score   <= '0;
      r_combo   <= '0;
      r_perfect <= '0;
      r_good    <= '0;
      r_miss    <= '0;
    end else begin
      r_score   <= w_score_nxt;
      r_combo   <= w_combo_nxt;
      r_perfect <= w_perf_nxt;
      r_good    <= w_good_nxt;
      r_miss    <= w_miss_nxt;
    end
  end

  assign bus.score       = r_score;
  assign bus.combo       = r_combo;
  assign bus.perfect_hit = r_perfect;
  assign bus.good_hit    = r_good;
  assign bus.miss        = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_ddr_hit_judge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_hit_judge
//  Purpose  : Self-checking bench for ddr_hit_judge: directed vector table,
//             hand-written corner sequences and random traffic compared with
//             a timestamp-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ddr_hit_judge;

  localparam int NP   = 2;
  localparam int NL   = 4;
  localparam int WP   = 2;
  localparam int WG   = 6;
  localparam int SW   = 7;
  localparam int SMAX = 99;
  localparam int CW   = 8;
  localparam int CMAX = 255;
  localparam int NK   = NP * NL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_hit_judge_if #(.NUM_PLAYERS(NP), .NUM_LANES(NL), .SCORE_W(SW), .COMBO_W(CW)) bus ();

  ddr_hit_judge #(
    .NUM_PLAYERS (NP), .NUM_LANES (NL), .WIN_PERFECT (WP), .WIN_GOOD (WG),
    .SCORE_W (SW), .SCORE_MAX (SMAX), .COMBO_W (CW)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  // Each armed lane remembers the global tick count at arrival; its age is
  // simply the number of ticks seen since then.
  int          m_score [NP];
  int          m_combo [NP];
  bit          m_armed [NP][NL];
  int          m_stamp [NP][NL];
  int          m_ticks;
  logic [NK-1:0] m_prev;
  logic [NP-1:0] m_perf, m_good, m_miss;

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_score[p] = 0;
      m_combo[p] = 0;
      for (int l = 0; l < NL; l++) begin
        m_armed[p][l] = 1'b0;
        m_stamp[p][l] = 0;
      end
    end
    m_ticks = 0;
    m_prev  = '1;
    m_perf  = '0;
    m_good  = '0;
    m_miss  = '0;
  endfunction

  function automatic void model_step(input bit tk, input bit nv, input logic [NL-1:0] lanes,
                                     input logic [NK-1:0] keys, input bit act, input bit clr);
    logic [NK-1:0] press;
    int tnext, el, np_, ng, nm, ns;
    bit pr, nt;
    press  = keys & ~m_prev;
    m_prev = keys;
    tnext  = m_ticks + (tk ? 1 : 0);
    m_perf = '0; m_good = '0; m_miss = '0;
    for (int p = 0; p < NP; p++) begin
      np_ = 0; ng = 0; nm = 0; ns = 0;
      for (int l = 0; l < NL; l++) begin
        pr = press[p*NL + l];
        nt = nv && lanes[l];
        el = m_ticks - m_stamp[p][l];
        if (!act || clr) begin
          m_armed[p][l] = 1'b0;
        end else if (pr) begin
          if (m_armed[p][l]) begin
            if (el < WP) np_++; else ng++;
            m_armed[p][l] = nt;
            m_stamp[p][l] = tnext;
          end else if (nt) np_++;
          else ns++;
        end else if (nt) begin
          if (m_armed[p][l]) nm++;
          m_armed[p][l] = 1'b1;
          m_stamp[p][l] = tnext;
        end else if (m_armed[p][l] && tk && el == WG - 1) begin
          nm++;
          m_armed[p][l] = 1'b0;
        end
      end
      if (clr) begin
        m_score[p] = 0;
        m_combo[p] = 0;
      end else begin
        m_score[p] = (m_score[p] + 3*np_ + ng > SMAX) ? SMAX : m_score[p] + 3*np_ + ng;
        if (nm + ns > 0) m_combo[p] = 0;
        else m_combo[p] = (m_combo[p] + np_ + ng > CMAX) ? CMAX : m_combo[p] + np_ + ng;
        m_perf[p] = (np_ > 0);
        m_good[p] = (ng > 0);
        m_miss[p] = (nm > 0);
      end
    end
    m_ticks = tnext;
  endfunction

  function automatic void chk_model();
    for (int p = 0; p < NP; p++) begin
      chk("model_score", int'(bus.score[p*SW +: SW]), m_score[p]);
      chk("model_combo", int'(bus.combo[p*CW +: CW]), m_combo[p]);
    end
    chk("model_perfect", int'(bus.perfect_hit), int'(m_perf));
    chk("model_good",    int'(bus.good_hit),    int'(m_good));
    chk("model_miss",    int'(bus.miss),        int'(m_miss));
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input bit tk, input bit nv, input logic [NL-1:0] lanes,
                       input logic [NK-1:0] keys, input bit act, input bit clr);
    bus.tick         = tk;
    bus.note_valid   = nv;
    bus.note_lanes   = lanes;
    bus.player_keys  = keys;
    bus.game_active  = act;
    bus.clear_scores = clr;
    model_step(tk, nv, lanes, keys, act, clr);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            tk;
    bit            nv;
    logic [NL-1:0] lanes;
    logic [NK-1:0] keys;
    bit            clr;
    int            s0, s1, c0, c1;
    logic [1:0]    pf, gd, ms;
  } vec_t;

  localparam int NROWS = 23;
  vec_t tbl [NROWS];

  logic [NK-1:0] rkeys;

  initial begin
    bus.tick = 1'b0; bus.note_valid = 1'b0; bus.note_lanes = '0;
    bus.player_keys = '1; bus.game_active = 1'b1; bus.clear_scores = 1'b0;
    model_reset();

    //            tk nv lanes keys   clr  s0 s1 c0 c1  pf     gd     ms
    tbl[0]  = '{1'b0,1'b0,4'h0,8'hFF,1'b0, 0,0,0,0, 2'b00,2'b00,2'b00}; // key held from reset
    tbl[1]  = '{1'b0,1'b0,4'h0,8'h00,1'b0, 0,0,0,0, 2'b00,2'b00,2'b00}; // release is not a press
    tbl[2]  = '{1'b0,1'b1,4'h1,8'h00,1'b0, 0,0,0,0, 2'b00,2'b00,2'b00}; // note lane 0
    tbl[3]  = '{1'b1,1'b0,4'h0,8'h00,1'b0, 0,0,0,0, 2'b00,2'b00,2'b00}; // age 1
    tbl[4]  = '{1'b0,1'b0,4'h0,8'h01,1'b0, 3,0,1,0, 2'b01,2'b00,2'b00}; // P0 perfect
    tbl[5]  = '{1'b0,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00};
    tbl[6]  = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00}; // P1 age 2
    tbl[7]  = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00};
    tbl[8]  = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00};
    tbl[9]  = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00}; // P1 age 5
    tbl[10] = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b10}; // P1 expiry miss
    tbl[11] = '{1'b0,1'b1,4'h4,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00}; // note lane 2
    tbl[12] = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00};
    tbl[13] = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00};
    tbl[14] = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00};
    tbl[15] = '{1'b1,1'b0,4'h0,8'h00,1'b0, 3,0,1,0, 2'b00,2'b00,2'b00}; // age 4
    tbl[16] = '{1'b0,1'b0,4'h0,8'h04,1'b0, 4,0,2,0, 2'b00,2'b01,2'b00}; // P0 good
    tbl[17] = '{1'b1,1'b0,4'h0,8'h00,1'b0, 4,0,2,0, 2'b00,2'b00,2'b00};
    tbl[18] = '{1'b1,1'b0,4'h0,8'h00,1'b0, 4,0,2,0, 2'b00,2'b00,2'b10}; // P1 miss
    tbl[19] = '{1'b0,1'b1,4'h3,8'h00,1'b0, 4,0,2,0, 2'b00,2'b00,2'b00}; // two-lane note
    tbl[20] = '{1'b0,1'b0,4'h0,8'h03,1'b0,10,0,4,0, 2'b01,2'b00,2'b00}; // double perfect
    tbl[21] = '{1'b0,1'b0,4'h0,8'h00,1'b0,10,0,4,0, 2'b00,2'b00,2'b00};
    tbl[22] = '{1'b0,1'b0,4'h0,8'h00,1'b1, 0,0,0,0, 2'b00,2'b00,2'b00}; // clear

    // Reset state with keys held.
    #1;
    chk("reset_score", int'(bus.score), 0);
    chk("reset_combo", int'(bus.combo), 0);
    chk("reset_pulses", int'({bus.perfect_hit, bus.good_hit, bus.miss}), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NROWS; i++) begin
      cycle(tbl[i].tk, tbl[i].nv, tbl[i].lanes, tbl[i].keys, 1'b1, tbl[i].clr);
      chk($sformatf("tbl%0d_score0", i), int'(bus.score[SW-1:0]),   tbl[i].s0);
      chk($sformatf("tbl%0d_score1", i), int'(bus.score[2*SW-1:SW]), tbl[i].s1);
      chk($sformatf("tbl%0d_combo0", i), int'(bus.combo[CW-1:0]),   tbl[i].c0);
      chk($sformatf("tbl%0d_combo1", i), int'(bus.combo[2*CW-1:CW]), tbl[i].c1);
      chk($sformatf("tbl%0d_perfect", i), int'(bus.perfect_hit), int'(tbl[i].pf));
      chk($sformatf("tbl%0d_good", i),    int'(bus.good_hit),    int'(tbl[i].gd));
      chk($sformatf("tbl%0d_miss", i),    int'(bus.miss),        int'(tbl[i].ms));
    end

    // ---- saturation: two goods then perfects up to score 98, 99, combo 255
    for (int g = 0; g < 2; g++) begin
      cycle(1'b0, 1'b1, 4'h1, 8'h00, 1'b1, 1'b0); chk_model();
      cycle(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();
      cycle(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();
      cycle(1'b0, 1'b0, 4'h0, 8'h01, 1'b1, 1'b0); chk_model();
      chk("sat_good_pulse", int'(bus.good_hit[0]), 1);
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();
    end
    for (int k = 0; k < 32; k++) begin
      cycle(1'b0, 1'b1, 4'h1, 8'h01, 1'b1, 1'b0); chk_model();
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();
    end
    chk("sat_score98", int'(bus.score[SW-1:0]), 98);
    chk("sat_combo34", int'(bus.combo[CW-1:0]), 34);
    cycle(1'b0, 1'b1, 4'h1, 8'h01, 1'b1, 1'b0);
    chk("sat_score99", int'(bus.score[SW-1:0]), 99);
    chk("sat_perfect", int'(bus.perfect_hit[0]), 1);
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 220; k++) begin
      cycle(1'b0, 1'b1, 4'h1, 8'h01, 1'b1, 1'b0); chk_model();
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    end
    chk("sat_combo255", int'(bus.combo[CW-1:0]), 255);
    cycle(1'b0, 1'b1, 4'h1, 8'h01, 1'b1, 1'b0);
    chk("sat_combo_hold", int'(bus.combo[CW-1:0]), 255);
    chk("sat_score_hold", int'(bus.score[SW-1:0]), 99);
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);

    // ---- stray press breaks combo; re-arrival misses and restarts window
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, 4'h1, 8'h01, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    end
    chk("stray_pre_combo", int'(bus.combo[CW-1:0]), 5);
    chk("stray_pre_score", int'(bus.score[SW-1:0]), 15);
    cycle(1'b0, 1'b0, 4'h0, 8'h08, 1'b1, 1'b0);
    chk("stray_combo", int'(bus.combo[CW-1:0]), 0);
    chk("stray_score", int'(bus.score[SW-1:0]), 15);
    chk("stray_pulses", int'({bus.perfect_hit[0], bus.good_hit[0], bus.miss[0]}), 0);
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();
    cycle(1'b0, 1'b1, 4'h2, 8'h00, 1'b1, 1'b0); chk_model();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();
    end
    cycle(1'b0, 1'b1, 4'h2, 8'h00, 1'b1, 1'b0);
    chk("rearm_miss", int'(bus.miss[0]), 1);
    chk_model();
    cycle(1'b0, 1'b0, 4'h0, 8'h02, 1'b1, 1'b0);
    chk("rearm_fresh_perfect", int'(bus.perfect_hit[0]), 1);
    chk_model();
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();

    // ---- press coinciding with expiry tick grades good
    cycle(1'b0, 1'b1, 4'h8, 8'h00, 1'b1, 1'b0); chk_model();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();
    end
    cycle(1'b1, 1'b0, 4'h0, 8'h08, 1'b1, 1'b0);
    chk("expiry_press_good", int'(bus.good_hit[0]), 1);
    chk("expiry_press_missvec", int'(bus.miss), 2);
    cycle(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0); chk_model();

    // ---- game inactive closes windows: no pulse, no later miss
    cycle(1'b0, 1'b1, 4'h1, 8'h00, 1'b1, 1'b0); chk_model();
    cycle(1'b1, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0);
    chk("inactive_nopulse", int'({bus.perfect_hit, bus.good_hit, bus.miss}), 0);
    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
      chk("inactive_nomiss", int'(bus.miss), 0);
    end

    // ---- reset mid-window discards the note without a miss
    cycle(1'b0, 1'b1, 4'h1, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_score", int'(bus.score), 0);
    chk("midrst_combo", int'(bus.combo), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
      chk("midrst_nomiss", int'(bus.miss), 0);
      chk_model();
    end

    // ---- random traffic against the model
    rkeys = '0;
    for (int k = 0; k < 3000; k++) begin
      bit tk, nv, act, clr;
      logic [NL-1:0] lanes;
      tk    = ((k / 200) % 3 == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      nv    = ($urandom_range(0, 3) == 0);
      lanes = NL'($urandom);
      rkeys = rkeys ^ NK'($urandom & $urandom);
      act   = ($urandom_range(0, 60) != 0);
      clr   = ($urandom_range(0, 250) == 0);
      cycle(tk, nv, lanes, rkeys, act, clr);
      chk_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_hit_judge.md
# ddr_hit_judge

Parametrised hit-judging and scoring engine for the dance game: N players × L lanes, graded timing windows (perfect/good/miss), saturating scores and combo counters. Sits between the debounced player inputs plus the arrow pattern/render path (which flags when a note reaches the target line) and the HEX/VGA score display. It replaces the fixed two-player, four-lane, perfect-only hit flags with per-lane window state machines and per-player arithmetic.

## Interface
- NUM_PLAYERS, 2, player count
- NUM_LANES, 4, lanes per player (bit 0 up, 1 down, 2 right, 3 left)
- WIN_PERFECT, 2, ticks after note arrival that still grade perfect
- WIN_GOOD, 6, total window length in ticks (must be > WIN_PERFECT)
- SCORE_W, 7, score width per player
- SCORE_MAX, 99, score saturation value (≤ 2^SCORE_W−1)
- COMBO_W, 8, combo width per player
- CLOCK_50  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low (0 = reset)
- tick  in  1  window time-base strobe, one cycle wide
- game_active  in  1  0 = all windows closed, no judging, scores held
- clear_scores  in  1  synchronous clear of scores/combos/windows
- note_valid  in  1  note(s) at target line this cycle
- note_lanes  in  NUM_LANES  lanes carrying a note (shared by all players)
- player_keys  in  NUM_PLAYERS*NUM_LANES  debounced key levels, player p at [p*NUM_LANES +: NUM_LANES]
- score  out  NUM_PLAYERS*SCORE_W  per-player score
- combo  out  NUM_PLAYERS*COMBO_W  per-player current combo
- perfect_hit, good_hit, miss  out  NUM_PLAYERS each  one-cycle judge pulses

## Operation
- Key press = rising edge of player_keys vs. registered previous value; previous-value register resets to all ones (key held through reset is not a press).
- Per player-lane window FSM: IDLE, ARMED(age). note_valid & lane bit → ARMED, age=0. age increments on tick only.
- In ARMED: press with age < WIN_PERFECT → perfect, →IDLE; press with WIN_PERFECT ≤ age < WIN_GOOD → good, →IDLE; tick when age = WIN_GOOD−1 with no press → miss, →IDLE.
- Press in IDLE (no note) → stray: breaks combo, no points, no pulse.
- Note and press same cycle on IDLE lane → perfect (age 0).
- New note on ARMED lane without press → old note judged miss, window restarts age=0 same cycle.
- New note and press same cycle on ARMED lane → press judges old note by its age, new note arms at age 0.
- Press and expiry tick same cycle → press wins (graded good).
- Per player per cycle: P = perfect count, G = good count, F = miss + stray count across lanes.
- score ← min(score + 3·P + G, SCORE_MAX); computed at SCORE_W+3 bits before saturation.
- combo ← (F>0) ? 0 : sat(combo + P + G, 2^COMBO_W−1).
- perfect_hit[p] = P>0, good_hit[p] = G>0, miss[p] = miss count>0 (stray excluded).
- game_active=0: all lanes forced IDLE, no pulses, score/combo held, edge register still tracks keys.
- clear_scores: score, combo, all lanes → 0/IDLE next cycle; overrides events that cycle.

## Timing
- Reset values: score 0, combo 0, all pulses 0, all lanes IDLE, key-previous all ones.
- Judge latency: press/note/tick in cycle n → pulse and updated score/combo visible cycle n+1 (registered outputs).
- Pulses exactly one cycle; consecutive-cycle events give consecutive pulses.
- Reset mid-window: window discarded, no miss reported.
- tick asserted continuously is legal (age advances every cycle).

## Structure
- Package ddr_judge_pkg: judge-result enum (NONE, PERFECT, GOOD, MISS, STRAY), PTS_PERFECT=3, PTS_GOOD=1, saturating-add function.
- Sub-module ddr_lane_judge: one window FSM + age counter, outputs judge result; instantiated NUM_PLAYERS×NUM_LANES via generate.
- Top: edge detect, per-player popcount of results, score/combo registers.

## Test plan
- Reset 0 then 1, key held throughout → no pulses, score 0, combo 0.
- Note lane 0, P0 press 1 tick later → perfect_hit[0] next cycle, score 3, combo 1; P1 untouched.
- Note lane 2, P0 press at age 4 → good_hit, score +1; no press for 6 ticks → miss, combo 0.
- P0 presses lanes 0,1 perfect same cycle on a two-lane note → score +6, combo +2, single perfect_hit pulse.
- Score at 98, perfect → 99 (saturated); combo at 255, hit → stays 255.
- Stray press in IDLE with combo 5 → combo 0, score unchanged, no pulse; note re-arrival on ARMED lane → miss plus fresh window.
